// File: rtl/bsas_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bsas_op_sequencer
// Purpose  : Request FIFO and N/nADD start-done sequencer for the bit-serial
//            adder/subtractor; returns results with overflow/timeout flags.
// Revision : 1.0
// ============================================================================
module bsas_op_sequencer #(
    parameter int WIDTH   = 5,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 31
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_x,
    input  logic [WIDTH-1:0]       in_y,
    input  logic                   in_sub,
    output logic [WIDTH-1:0]       Xin,
    output logic [WIDTH-1:0]       Yin,
    output logic                   N,
    output logic                   nADD,
    input  logic                   done,
    input  logic [WIDTH-1:0]       Xout,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WIDTH-1:0]       res_value,
    output logic                   res_sub,
    output logic                   res_ovf,
    output logic                   res_timeout,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] C_TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] C_DEPTH      = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_WAIT    = 3'd2,
        S_RELEASE = 3'd3,
        S_OUTPUT  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [2*WIDTH:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] xin_q, xin_d, yin_q, yin_d;
    logic [WIDTH-1:0] res_value_q, res_value_d;
    logic             sub_q, sub_d, n_q, n_d, nadd_q, nadd_d;
    logic             load_cnt_q, load_cnt_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             res_valid_q, res_valid_d, res_sub_q, res_sub_d;
    logic             res_ovf_q, res_ovf_d, res_timeout_q, res_timeout_d;
    logic             busy_q, busy_d;

    logic             push, pop, ovf;
    logic [2*WIDTH:0] head;

    assign in_ready = (count_q < C_DEPTH);
    assign push     = in_valid & in_ready;
    assign pop      = (state_q == S_IDLE) && (count_q != '0);
    assign head     = mem_q[rd_ptr_q];

    // Signed overflow: operand sign relation depends on the opcode, result sign must follow X.
    assign ovf = (sub_q ? (xin_q[WIDTH-1] != yin_q[WIDTH-1]) : (xin_q[WIDTH-1] == yin_q[WIDTH-1]))
                 & (Xout[WIDTH-1] != xin_q[WIDTH-1]);

    always_comb begin
        wr_ptr_d      = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d      = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        state_d       = state_q;
        xin_d         = xin_q;
        yin_d         = yin_q;
        sub_d         = sub_q;
        n_d           = n_q;
        nadd_d        = nadd_q;
        load_cnt_d    = load_cnt_q;
        timer_d       = timer_q;
        res_valid_d   = res_valid_q;
        res_value_d   = res_value_q;
        res_sub_d     = res_sub_q;
        res_ovf_d     = res_ovf_q;
        res_timeout_d = res_timeout_q;

        case (state_q)
            S_IDLE: begin
                n_d    = 1'b0;
                nadd_d = 1'b0;
                if (pop) begin
                    sub_d      = head[2*WIDTH];
                    xin_d      = head[2*WIDTH-1:WIDTH];
                    yin_d      = head[WIDTH-1:0];
                    load_cnt_d = 1'b0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                if (load_cnt_q) begin
                    n_d     = 1'b1;
                    nadd_d  = sub_q;
                    timer_d = '0;
                    state_d = S_WAIT;
                end else begin
                    load_cnt_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (done) begin
                    res_value_d   = Xout;
                    res_ovf_d     = ovf;
                    res_timeout_d = 1'b0;
                    res_sub_d     = sub_q;
                    n_d           = 1'b0;
                    nadd_d        = 1'b0;
                    state_d       = S_RELEASE;
                end else if (timer_q == C_TIMER_LAST) begin
                    res_value_d   = '0;
                    res_ovf_d     = 1'b0;
                    res_timeout_d = 1'b1;
                    res_sub_d     = sub_q;
                    n_d           = 1'b0;
                    nadd_d        = 1'b0;
                    state_d       = S_RELEASE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_RELEASE: begin
                // Keep N low until the BSAS has dropped done so a new start cannot alias the old one.
                if (!done) begin
                    res_valid_d = 1'b1;
                    state_d     = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_sub, in_x, in_y};
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            xin_q         <= '0;
            yin_q         <= '0;
            sub_q         <= 1'b0;
            n_q           <= 1'b0;
            nadd_q        <= 1'b0;
            load_cnt_q    <= 1'b0;
            timer_q       <= '0;
            res_valid_q   <= 1'b0;
            res_value_q   <= '0;
            res_sub_q     <= 1'b0;
            res_ovf_q     <= 1'b0;
            res_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            xin_q         <= xin_d;
            yin_q         <= yin_d;
            sub_q         <= sub_d;
            n_q           <= n_d;
            nadd_q        <= nadd_d;
            load_cnt_q    <= load_cnt_d;
            timer_q       <= timer_d;
            res_valid_q   <= res_valid_d;
            res_value_q   <= res_value_d;
            res_sub_q     <= res_sub_d;
            res_ovf_q     <= res_ovf_d;
            res_timeout_q <= res_timeout_d;
            busy_q        <= busy_d;
        end
    end

    assign Xin         = xin_q;
    assign Yin         = yin_q;
    assign N           = n_q;
    assign nADD        = nadd_q;
    assign res_valid   = res_valid_q;
    assign res_value   = res_value_q;
    assign res_sub     = res_sub_q;
    assign res_ovf     = res_ovf_q;
    assign res_timeout = res_timeout_q;
    assign busy        = busy_q;
    assign fifo_count  = count_q;

endmodule
`default_nettype wire
